// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data memory between the pipeline Memory stage
// and a DMA/loader port that takes bursts on idle cycles or after a bounded wait.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int BURST_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [BURST_W-1:0] dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_beat,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_WE,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic {S_PIPE, S_DMA} state_t;
  state_t state, state_next;
  logic [WW-1:0] wait_cnt;
  logic [BURST_W-1:0] beat_cnt, len;
  logic [ADDR_W-1:0] base;
  logic we, dma, go, last;
  assign dma  = state == S_DMA;
  assign go   = dma_req & (!pipe_req | wait_cnt == WW'(MAX_WAIT - 1));
  assign last = beat_cnt == len;
  always_comb begin
    state_next = dma ? (last ? S_PIPE : S_DMA) : (go ? S_DMA : S_PIPE);
    mem_A      = dma ? base + ADDR_W'({beat_cnt, 2'b00}) : pipe_addr;
    mem_WD     = dma ? dma_wdata : pipe_wdata;
    mem_WE     = !rst & (dma ? we : pipe_req & pipe_we);
    pipe_stall = !rst & dma & pipe_req;
    dma_beat   = dma;
    pipe_rdata = mem_RD;
    dma_rdata  = mem_RD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_PIPE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      len      <= '0;
      base     <= '0;
      we       <= 1'b0;
      dma_gnt  <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state    <= state_next;
      dma_gnt  <= !dma & go;
      dma_done <= dma & last;
      if (!dma) begin
        // counts only pipeline-served cycles while DMA is waiting
        wait_cnt <= (!dma_req || go) ? '0 : wait_cnt + 1'b1;
        if (go) begin
          base     <= dma_addr;
          len      <= dma_len;
          we       <= dma_we;
          beat_cnt <= '0;
        end
      end else if (!last) beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule
